linebuf_pingpong_ctrl: RTL
==========================

Name: linebuf_pingpong_ctrl

Overview:
- Sequences a pair of 1024x4 sprite line buffers (LineBuf instances) as a ping-pong pair.
- During each scanline, one buffer is the render buffer. It accepts sprite pixel beats from the sprite engine through a valid/ready handshake.
- The other buffer is the display buffer. It is read out against the beam and erased as it is read.
- Roles swap on every hblank_start pulse. The block sits between the sprite renderer and the video mixer.

Parameters:
- AW, 10, line-buffer address width (x position).
- DW, 4, pixel width.
- TRANSP, 0, pixel value treated as transparent; transparent beats are never written.

Ports:
- cl  in  1  system clock; drives both line-buffer ports.
- reset  in  1  asynchronous, active-high reset.
- hblank_start  in  1  one-cycle pulse; swaps buffer roles.
- spr_valid  in  1  sprite pixel beat valid.
- spr_ready  out  1  controller accepts the beat.
- spr_x  in  AW  beat x position.
- spr_px  in  DW  beat pixel.
- spr_last  in  1  marks the last beat of the line's sprite list.
- disp_en  in  1  display read strobe.
- disp_x  in  AW  display x position.
- disp_px  out  DW  display pixel, one cycle after disp_en.
- render_busy  out  1  render FSM is in WRITE.
- overrun  out  1  sticky: a swap occurred before the render side reached DONE.
- ovr_clr  in  1  clears overrun.
- b0_wen/b1_wen  out  1  write enable to buffer 0/1 write port.
- b0_wad/b1_wad  out  AW  write address.
- b0_wdt/b1_wdt  out  DW  write data.
- b0_rad/b1_rad  out  AW  read address.
- b0_rwe/b1_rwe  out  1  read-port erase strobe; the buffer writes 0 on its read port.
- b0_rdt/b1_rdt  in  DW  registered read data from the buffer.

Behaviour:
- Reset (async, active-high): sel=0 (render=b0, display=b1), FSM=IDLE, overrun=0, disp_px=0, spr_ready=0, render_busy=0, all wen/rwe=0, all addresses and data=0.
- Render FSM states:
  - IDLE: entered only from reset; spr_ready=0.
  - WRITE: spr_ready=1.
  - DONE: spr_ready=0.
- FSM transitions:
  - On hblank_start from any state: sel toggles and FSM goes to WRITE.
  - If the state was WRITE at that swap, overrun is set.
  - In WRITE, an accepted beat with spr_last=1 moves the FSM to DONE.
- Handshake:
  - A beat is accepted when spr_valid & spr_ready.
  - spr_ready is forced to 0 in any cycle where hblank_start=1, so there is never an accept on a swap cycle.
  - The renderer holds the beat until it is accepted.
- Write path:
  - Combinational from the accepted beat.
  - b[sel]_wen = accept & (spr_px != TRANSP); wad=spr_x; wdt=spr_px.
  - Later writes to the same x overwrite earlier ones, so the renderer sends lowest-priority sprites first.
  - The display buffer's wen is always 0.
- Read/erase path:
  - b[~sel]_rad = disp_x; b[~sel]_rwe = disp_en.
  - The render buffer's rwe is 0 and its rad is held at 0.
  - The buffer returns old data on read-with-erase at the same address.
- disp_px:
  - Register sel_d and en_d one cycle.
  - disp_px = en_d ? b[~sel_d]_rdt : 0, registered as a 1-cycle latency from disp_x.
  - A swap does not corrupt the pixel in flight.
- overrun: set as above; cleared by ovr_clr. If set and clear happen in the same cycle, set wins.
- Boundaries:
  - x wraps naturally at 2^AW; no range check.
  - disp_en during the swap cycle reads the buffer that becomes display after the swap.
  - Reset mid-line leaves buffer contents unerased. The first full line after reset may show stale pixels, which is accepted.

Optional Feature:
- LINEBUF_FLIPX_EN.
- Defined: adds input flip_x (1). When flip_x=1, the write address is ~spr_x (mirror about 2^AW-1); the read side is unchanged. flip_x is sampled per beat.
- Undefined: no flip_x port; the write address is always spr_x.

Decomposition:
- Package linebuf_pkg: AW, DW, TRANSP defaults; render-state enum {IDLE, WRITE, DONE}.
- One sub-module, linebuf_side_mux: a pure steering mux that maps render/display signals onto b0/b1 by sel.
- FSM, handshake, and overrun logic stay in the top level.

Test Plan:
- Reset, then hblank_start. Expect sel=1, render_busy=1, spr_ready=1. Beats (x=5,px=3),(x=6,px=0),(x=7,px=9,last) give b1_wen pulses at x=5 and x=7 only, then FSM=DONE and spr_ready=0.
- Next hblank_start, then disp_en with disp_x=4,5,6,7 on consecutive cycles. Expect disp_px=0,3,0,9, each one cycle later. b1_rwe pulses at each address, so a second read line returns all 0.
- Beats to x=10 with px=2 then px=0xA. Display reads x=10 as 0xA.
- hblank_start while spr_valid=1 in WRITE without last. Expect spr_ready=0 that cycle, overrun=1. ovr_clr then drops overrun; ovr_clr together with another overrun event keeps it 1.
- Assert reset mid-WRITE with spr_valid=1. Expect all outputs at reset values immediately (async), with no wen/rwe pulse.
- LINEBUF_FLIPX_EN with flip_x=1, beat x=0x003 px=5. Expect b_wad=0x3FC.

Source files
------------

// File: rtl/linebuf_pkg.sv
// rtl/linebuf_pkg.sv - shared widths, transparent pixel code and render-state enum
package linebuf_pkg;
  localparam int LB_AW     = 10;
  localparam int LB_DW     = 4;
  localparam int LB_TRANSP = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } render_state_e;
endpackage

// File: rtl/linebuf_side_mux.sv
// rtl/linebuf_side_mux.sv - steers render/display traffic onto b0/b1 by i_sel
// i_sel names the render buffer; the other one is the display buffer.
module linebuf_side_mux #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          i_sel,
  input  logic          i_wen,
  input  logic [AW-1:0] i_wad,
  input  logic [DW-1:0] i_wdt,
  input  logic [AW-1:0] i_rad,
  input  logic          i_rwe,
  output logic          o_b0_wen,
  output logic [AW-1:0] o_b0_wad,
  output logic [DW-1:0] o_b0_wdt,
  output logic [AW-1:0] o_b0_rad,
  output logic          o_b0_rwe,
  output logic          o_b1_wen,
  output logic [AW-1:0] o_b1_wad,
  output logic [DW-1:0] o_b1_wdt,
  output logic [AW-1:0] o_b1_rad,
  output logic          o_b1_rwe
);
  assign o_b0_wen = !i_sel && i_wen;
  assign o_b0_wad = i_sel ? '0 : i_wad;
  assign o_b0_wdt = i_sel ? '0 : i_wdt;
  assign o_b1_wen = i_sel && i_wen;
  assign o_b1_wad = i_sel ? i_wad : '0;
  assign o_b1_wdt = i_sel ? i_wdt : '0;

  // Render side keeps its read port parked at address 0 with erase off.
  assign o_b0_rad = i_sel ? i_rad : '0;
  assign o_b0_rwe = i_sel && i_rwe;
  assign o_b1_rad = i_sel ? '0 : i_rad;
  assign o_b1_rwe = !i_sel && i_rwe;
endmodule

// File: rtl/linebuf_pingpong_ctrl.sv
// rtl/linebuf_pingpong_ctrl.sv - ping-pong render/display sequencer for two sprite line buffers
// Optional LINEBUF_FLIPX_EN adds i_flip_x to mirror the write address per beat.
module linebuf_pingpong_ctrl
  import linebuf_pkg::*;
#(
  parameter int AW     = LB_AW,
  parameter int DW     = LB_DW,
  parameter int TRANSP = LB_TRANSP
) (
  input  logic          i_cl,
  input  logic          i_reset,
  input  logic          i_hblank_start,
  input  logic          i_spr_valid,
  output logic          o_spr_ready,
  input  logic [AW-1:0] i_spr_x,
  input  logic [DW-1:0] i_spr_px,
  input  logic          i_spr_last,
`ifdef LINEBUF_FLIPX_EN
  input  logic          i_flip_x,
`endif
  input  logic          i_disp_en,
  input  logic [AW-1:0] i_disp_x,
  output logic [DW-1:0] o_disp_px,
  output logic          o_render_busy,
  output logic          o_overrun,
  input  logic          i_ovr_clr,
  output logic          o_b0_wen,
  output logic [AW-1:0] o_b0_wad,
  output logic [DW-1:0] o_b0_wdt,
  output logic [AW-1:0] o_b0_rad,
  output logic          o_b0_rwe,
  input  logic [DW-1:0] i_b0_rdt,
  output logic          o_b1_wen,
  output logic [AW-1:0] o_b1_wad,
  output logic [DW-1:0] o_b1_wdt,
  output logic [AW-1:0] o_b1_rad,
  output logic          o_b1_rwe,
  input  logic [DW-1:0] i_b1_rdt
);
  render_state_e r_state;
  logic          r_sel, r_sel_d, r_en_d, r_ovr;
  logic          w_ready, w_accept, w_wen, w_rwe, w_mux_sel;
  logic [AW-1:0] w_addr, w_wad, w_rad;
  logic [DW-1:0] w_wdt;

  assign w_ready  = (r_state == WRITE) && !i_hblank_start;
  assign w_accept = i_spr_valid && w_ready;
  assign w_wen    = w_accept && (i_spr_px != DW'(TRANSP));

`ifdef LINEBUF_FLIPX_EN
  assign w_addr = i_flip_x ? ~i_spr_x : i_spr_x;
`else
  assign w_addr = i_spr_x;
`endif

  assign w_wad = w_wen ? w_addr : '0;
  assign w_wdt = w_wen ? i_spr_px : '0;
  assign w_rwe = i_disp_en && !i_reset;
  assign w_rad = i_reset ? '0 : i_disp_x;

  // Steer with the post-swap selection so a read on the swap cycle hits the new display buffer.
  assign w_mux_sel = r_sel ^ i_hblank_start;

  linebuf_side_mux #(.AW(AW), .DW(DW)) u_side_mux (
    .i_sel    (w_mux_sel),
    .i_wen    (w_wen),
    .i_wad    (w_wad),
    .i_wdt    (w_wdt),
    .i_rad    (w_rad),
    .i_rwe    (w_rwe),
    .o_b0_wen (o_b0_wen),
    .o_b0_wad (o_b0_wad),
    .o_b0_wdt (o_b0_wdt),
    .o_b0_rad (o_b0_rad),
    .o_b0_rwe (o_b0_rwe),
    .o_b1_wen (o_b1_wen),
    .o_b1_wad (o_b1_wad),
    .o_b1_wdt (o_b1_wdt),
    .o_b1_rad (o_b1_rad),
    .o_b1_rwe (o_b1_rwe)
  );

  always_ff @(posedge i_cl or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_sel_d <= 1'b0;
      r_en_d  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sel_d <= w_mux_sel;
      r_en_d  <= i_disp_en;
      if (i_hblank_start) begin
        r_sel   <= ~r_sel;
        r_state <= WRITE;
      end else if (r_state == WRITE && w_accept && i_spr_last) begin
        r_state <= DONE;
      end
      if (i_hblank_start && r_state == WRITE) r_ovr <= 1'b1;
      else if (i_ovr_clr)                      r_ovr <= 1'b0;
    end
  end

  assign o_spr_ready   = w_ready;
  assign o_render_busy = (r_state == WRITE);
  assign o_overrun     = r_ovr;
  // The buffer's read data is already registered, so this mux completes the one-cycle latency.
  assign o_disp_px     = r_en_d ? (r_sel_d ? i_b0_rdt : i_b1_rdt) : '0;
endmodule
